ysyx_23060332_ifu: RTL

//  Instruction fetch stage directly upstream of the decode stage. Owns the PC, fetches one
//  32-bit instruction at a time over a valid/ready request + valid response memory port,

---
 rtl/ysyx_23060332_ifu_pkg.sv | 15 +
 rtl/ysyx_23060332_ifu_pc.sv | 35 +++
 rtl/ysyx_23060332_ifu.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared IFU definitions: reset PC, FSM state encodings, NOP and bus widths.
package ysyx_23060332_ifu_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int INST_W_DEF = 32;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    localparam logic [1:0] IFU_IDLE = 2'd0;
    localparam logic [1:0] IFU_REQ  = 2'd1;
    localparam logic [1:0] IFU_WAIT = 2'd2;
    localparam logic [1:0] IFU_HOLD = 2'd3;

endpackage

// File: rtl/ysyx_23060332_ifu_pc.sv
// IFU program counter: reset load, redirect or +4 step, word alignment.
module ysyx_23060332_ifu_pc #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_load,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (jump_load) begin
            pc_next = jump_addr & ALIGN_MASK;
        end else if (inc) begin
            pc_next = pc + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC & ALIGN_MASK;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: request/response fetch FSM, decode handoff buffer.
// Define YSYX_23060332_IFU_PERF_EN to add fetch/stall/flush counters.
module ysyx_23060332_ifu
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr
`ifdef YSYX_23060332_IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt,
    output logic [63:0]       perf_flush_cnt
`endif
);

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic              drop;
    logic              drop_n;
    logic              pc_jump;
    logic              pc_inc;
    logic              latch;
    logic [ADDR_W-1:0] pc;

    ysyx_23060332_ifu_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .jump_load (pc_jump),
        .jump_addr (jump_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    assign imem_req_valid = (state == IFU_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == IFU_HOLD);

    always_comb begin
        state_n = state;
        drop_n  = drop;
        pc_jump = 1'b0;
        pc_inc  = 1'b0;
        latch   = 1'b0;
        case (state)
            IFU_IDLE: state_n = IFU_REQ;
            IFU_REQ: begin
                pc_jump = jump_en;
                if (imem_req_ready) begin
                    state_n = IFU_WAIT;
                    drop_n  = jump_en;
                end
            end
            IFU_WAIT: begin
                pc_jump = jump_en;
                if (imem_rsp_valid) begin
                    // A redirect in the response cycle kills that response too
                    if (drop || jump_en) begin
                        drop_n  = 1'b0;
                        state_n = IFU_REQ;
                    end else begin
                        latch   = 1'b1;
                        state_n = IFU_HOLD;
                    end
                end else if (jump_en) begin
                    drop_n = 1'b1;
                end
            end
            IFU_HOLD: begin
                if (inst_ready) begin
                    pc_jump = jump_en;
                    pc_inc  = !jump_en;
                    state_n = IFU_REQ;
                end else if (jump_en) begin
                    pc_jump = 1'b1;
                    state_n = IFU_REQ;
                end
            end
            default: state_n = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IFU_IDLE;
            drop      <= 1'b0;
            inst_o    <= '0;
            inst_addr <= '0;
        end else begin
            state <= state_n;
            drop  <= drop_n;
            if (latch) begin
                inst_o    <= imem_rsp_data;
                inst_addr <= pc;
            end
        end
    end

`ifdef YSYX_23060332_IFU_PERF_EN
    logic fetch_ev;
    logic stall_ev;
    logic flush_ev;

    assign fetch_ev = (state == IFU_HOLD) && inst_ready;
    assign stall_ev = (state == IFU_REQ) || (state == IFU_WAIT);
    assign flush_ev = ((state == IFU_WAIT) && imem_rsp_valid && (drop || jump_en))
                    || ((state == IFU_HOLD) && !inst_ready && jump_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fetch_ev) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (stall_ev) perf_stall_cnt <= perf_stall_cnt + 64'd1;
            if (flush_ev) perf_flush_cnt <= perf_flush_cnt + 64'd1;
        end
    end
`endif

endmodule
